// File: rtl/memoria_pkg.sv
// Shared definitions for the nRisc data-memory responder: FSM states,
// default port address and the wait-counter width.
package memoria_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESPERA   = 2'd1,
        RESPONDE = 2'd2,
        RETORNO  = 2'd3
    } estado_t;

    localparam logic [7:0] END_PORTA_PADRAO = 8'hFF;
    localparam int         LARG_CONT        = 4;

    // True when the address is neither the output port nor backed by RAM.
    function automatic logic fora_de_faixa(input logic [7:0] endereco,
                                           input logic [7:0] porta,
                                           input int         profundidade);
        return (endereco != porta) && (32'(endereco) >= 32'(profundidade));
    endfunction

endpackage

// File: rtl/memoria_dados_resp_if.sv
// Data-port bundle between the nRisc core (master) and the memory responder (slave).
interface memoria_dados_resp_if;

    logic       LerMem;
    logic       EscMem;
    logic [7:0] EndMemDados;
    logic [7:0] DadoEscritoMem;
    logic [7:0] DadoLidoMem;
    logic       Pronto;
    logic       Ocupado;
    logic       Erro;
    logic [7:0] SaidaPorta;

    modport master (
        output LerMem, EscMem, EndMemDados, DadoEscritoMem,
        input  DadoLidoMem, Pronto, Ocupado, Erro, SaidaPorta
    );

    modport slave (
        input  LerMem, EscMem, EndMemDados, DadoEscritoMem,
        output DadoLidoMem, Pronto, Ocupado, Erro, SaidaPorta
    );

endinterface

// File: rtl/ram_dados_sinc.sv
// Synchronous-write, registered-read byte array. Contents and read port are not reset;
// the read register only changes on an enabled read.
module ram_dados_sinc #(
    parameter int PROFUNDIDADE = 256,
    parameter int LARG_END     = $clog2(PROFUNDIDADE)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [LARG_END-1:0] endereco,
    input  logic [7:0]          din,
    output logic [7:0]          dout
);

    logic [7:0] mem_r [PROFUNDIDADE];
    logic [7:0] dout_r;

    // Single port: a write leaves the last read value on dout untouched.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[endereco] <= din;
            end else begin
                dout_r <= mem_r[endereco];
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/memoria_dados_resp.sv
// nRisc data-memory responder: latches a request, waits ESPERAS cycles, then performs
// the RAM / output-port access and pulses Pronto, followed by one dead cycle.
module memoria_dados_resp import memoria_pkg::*; #(
    parameter int         PROFUNDIDADE = 256,
    parameter int         ESPERAS      = 2,
    parameter logic [7:0] END_PORTA    = END_PORTA_PADRAO
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    memoria_dados_resp_if.slave  bus
);

    localparam int                   LARG_END = $clog2(PROFUNDIDADE);
    localparam logic [LARG_CONT-1:0] CARGA    = LARG_CONT'(ESPERAS);

    estado_t              estado_r;
    logic [LARG_CONT-1:0] cont_r;
    logic [7:0]           end_r;
    logic [7:0]           dado_r;
    logic [7:0]           saida_r;
    logic [7:0]           lido_r;
    logic                 ler_r;
    logic                 esc_r;
    logic                 usa_ram_r;
    logic                 pronto_r;
    logic                 ocupado_r;
    logic                 erro_r;

    logic                 ambos_s;
    logic                 porta_s;
    logic                 fora_s;
    logic                 ram_ok_s;
    logic                 ram_en_s;
    logic [7:0]           ram_dout_s;

    // Classify the latched request; the categories are mutually exclusive.
    always_comb begin
        ambos_s  = 1'b0;
        porta_s  = 1'b0;
        fora_s   = 1'b0;
        ram_ok_s = 1'b0;
        if (ler_r && esc_r) begin
            ambos_s = 1'b1;
        end else if (end_r == END_PORTA) begin
            porta_s = 1'b1;
        end else if (fora_de_faixa(end_r, END_PORTA, PROFUNDIDADE)) begin
            fora_s = 1'b1;
        end else begin
            ram_ok_s = 1'b1;
        end
    end

    assign ram_en_s = ram_ok_s && (estado_r == RESPONDE);

    ram_dados_sinc #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARG_END     (LARG_END)
    ) u_ram (
        .clk      (Clock),
        .en       (ram_en_s),
        .we       (esc_r),
        .endereco (end_r[LARG_END-1:0]),
        .din      (dado_r),
        .dout     (ram_dout_s)
    );

    // Access sequencer with registered handshake outputs and the port register.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            estado_r  <= OCIOSO;
            cont_r    <= '0;
            end_r     <= 8'h00;
            dado_r    <= 8'h00;
            saida_r   <= 8'h00;
            lido_r    <= 8'h00;
            ler_r     <= 1'b0;
            esc_r     <= 1'b0;
            usa_ram_r <= 1'b0;
            pronto_r  <= 1'b0;
            ocupado_r <= 1'b0;
            erro_r    <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            erro_r   <= 1'b0;
            case (estado_r)
                OCIOSO: begin
                    if (bus.LerMem || bus.EscMem) begin
                        end_r     <= bus.EndMemDados;
                        dado_r    <= bus.DadoEscritoMem;
                        ler_r     <= bus.LerMem;
                        esc_r     <= bus.EscMem;
                        cont_r    <= CARGA;
                        ocupado_r <= 1'b1;
                        estado_r  <= (ESPERAS == 0) ? RESPONDE : ESPERA;
                    end else begin
                        ocupado_r <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (cont_r <= 4'd1) begin
                        cont_r   <= 4'd0;
                        estado_r <= RESPONDE;
                    end else begin
                        cont_r <= cont_r - 4'd1;
                    end
                end
                RESPONDE: begin
                    pronto_r <= 1'b1;
                    erro_r   <= ambos_s || fora_s;
                    estado_r <= RETORNO;
                    // A RAM read lands in ram_dout_s on this same edge.
                    if (porta_s && esc_r) begin
                        saida_r <= dado_r;
                    end else if (porta_s) begin
                        lido_r    <= saida_r;
                        usa_ram_r <= 1'b0;
                    end else if (fora_s && ler_r) begin
                        lido_r    <= 8'h00;
                        usa_ram_r <= 1'b0;
                    end else if (ram_ok_s && ler_r) begin
                        usa_ram_r <= 1'b1;
                    end else begin
                        usa_ram_r <= usa_ram_r;
                    end
                end
                RETORNO: begin
                    ocupado_r <= 1'b0;
                    estado_r  <= OCIOSO;
                end
                default: begin
                    ocupado_r <= 1'b0;
                    estado_r  <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.DadoLidoMem = usa_ram_r ? ram_dout_s : lido_r;
    assign bus.Pronto      = pronto_r;
    assign bus.Ocupado     = ocupado_r;
    assign bus.Erro        = erro_r;
    assign bus.SaidaPorta  = saida_r;

endmodule

// File: tb/tb_memoria_dados_resp.sv
// Bench for memoria_dados_resp: two configurations driven side by side and checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_memoria_dados_resp;

    localparam int E_A = 2;
    localparam int P_A = 256;
    localparam int E_B = 0;
    localparam int P_B = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memoria_dados_resp_if bus_a ();
    memoria_dados_resp_if bus_b ();

    memoria_dados_resp #(.PROFUNDIDADE(P_A), .ESPERAS(E_A), .END_PORTA(8'hFF)) dut_a (
        .Clock(clk), .ResetN(rst_n), .bus(bus_a.slave));
    memoria_dados_resp #(.PROFUNDIDADE(P_B), .ESPERAS(E_B), .END_PORTA(8'hFF)) dut_b (
        .Clock(clk), .ResetN(rst_n), .bus(bus_b.slave));

    logic [1:0] ler_v = 2'b00;
    logic [1:0] esc_v = 2'b00;
    logic [7:0] end_v [2];
    logic [7:0] dw_v  [2];
    logic [1:0] pr_v, oc_v, er_v;
    logic [7:0] ld_v [2];
    logic [7:0] sp_v [2];

    assign bus_a.LerMem = ler_v[0];
    assign bus_a.EscMem = esc_v[0];
    assign bus_a.EndMemDados = end_v[0];
    assign bus_a.DadoEscritoMem = dw_v[0];
    assign bus_b.LerMem = ler_v[1];
    assign bus_b.EscMem = esc_v[1];
    assign bus_b.EndMemDados = end_v[1];
    assign bus_b.DadoEscritoMem = dw_v[1];
    assign pr_v = {bus_b.Pronto, bus_a.Pronto};
    assign oc_v = {bus_b.Ocupado, bus_a.Ocupado};
    assign er_v = {bus_b.Erro, bus_a.Erro};
    assign ld_v[0] = bus_a.DadoLidoMem;
    assign ld_v[1] = bus_b.DadoLidoMem;
    assign sp_v[0] = bus_a.SaidaPorta;
    assign sp_v[1] = bus_b.SaidaPorta;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nome, input int i, input logic [31:0] got, input logic [31:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nome, i, $time, got, exp_v);
        end
    endtask

    function automatic int esp_of(input int i);
        return (i == 0) ? E_A : E_B;
    endfunction

    function automatic int prof_of(input int i);
        return (i == 0) ? P_A : P_B;
    endfunction

    // Transaction-level reference: an accepted request completes E+1 edges later and
    // the responder accepts again E+3 edges after the previous acceptance.
    logic [7:0] m_mem [2][256];
    bit         m_ok  [2][256];
    logic [7:0] m_porta [2];
    logic [7:0] m_lido  [2];
    bit         m_lido_ok [2];
    bit         act [2];
    int         done_at [2];
    int         next_free [2];
    bit         op_l [2];
    bit         op_e [2];
    logic [7:0] op_a [2];
    logic [7:0] op_d [2];
    bit         x_pr [2];
    bit         x_er [2];
    bit         x_oc [2];
    int         cyc;

    initial begin
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_porta[i] = 8'h00; m_lido[i] = 8'h00; m_lido_ok[i] = 1'b1;
            act[i] = 1'b0; next_free[i] = 0; done_at[i] = 0;
            x_pr[i] = 1'b0; x_er[i] = 1'b0; x_oc[i] = 1'b0;
            for (int a = 0; a < 256; a++) m_ok[i][a] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    act[i] = 1'b0; next_free[i] = 0;
                    m_porta[i] = 8'h00; m_lido[i] = 8'h00; m_lido_ok[i] = 1'b1;
                    x_pr[i] = 1'b0; x_er[i] = 1'b0; x_oc[i] = 1'b0;
                end else begin
                    x_pr[i] = 1'b0;
                    x_er[i] = 1'b0;
                    if (act[i] && cyc == done_at[i]) begin
                        x_pr[i] = 1'b1;
                        if (op_l[i] && op_e[i]) begin
                            x_er[i] = 1'b1;
                        end else if (op_a[i] == 8'hFF) begin
                            if (op_e[i]) m_porta[i] = op_d[i];
                            else begin m_lido[i] = m_porta[i]; m_lido_ok[i] = 1'b1; end
                        end else if (int'(op_a[i]) >= prof_of(i)) begin
                            x_er[i] = 1'b1;
                            if (op_l[i]) begin m_lido[i] = 8'h00; m_lido_ok[i] = 1'b1; end
                        end else if (op_e[i]) begin
                            m_mem[i][op_a[i]] = op_d[i];
                            m_ok[i][op_a[i]] = 1'b1;
                        end else begin
                            m_lido[i] = m_mem[i][op_a[i]];
                            m_lido_ok[i] = m_ok[i][op_a[i]];
                        end
                    end
                    if (act[i] && cyc > done_at[i]) act[i] = 1'b0;
                    if (cyc >= next_free[i] && (ler_v[i] || esc_v[i])) begin
                        act[i] = 1'b1;
                        done_at[i] = cyc + esp_of(i) + 1;
                        next_free[i] = cyc + esp_of(i) + 3;
                        op_l[i] = ler_v[i]; op_e[i] = esc_v[i];
                        op_a[i] = end_v[i]; op_d[i] = dw_v[i];
                    end
                    x_oc[i] = act[i] && (cyc <= done_at[i]);
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the reference.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("pronto", i, 32'(pr_v[i]), 32'(x_pr[i]));
                chk("erro", i, 32'(er_v[i]), 32'(x_er[i]));
                chk("ocupado", i, 32'(oc_v[i]), 32'(x_oc[i]));
                chk("saida_porta", i, 32'(sp_v[i]), 32'(m_porta[i]));
                if (m_lido_ok[i]) chk("dado_lido", i, 32'(ld_v[i]), 32'(m_lido[i]));
            end
        end
    end

    // One complete access; reports latency (edges from capture to Pronto) and Pronto-cycle outputs.
    task automatic acesso(input int i, input bit l, input bit e, input logic [7:0] a,
                          input logic [7:0] d, output int lat, output logic [7:0] dl,
                          output bit er, output logic [7:0] sp);
        @(negedge clk);
        ler_v[i] = l; esc_v[i] = e; end_v[i] = a; dw_v[i] = d;
        lat = -1; dl = 8'h00; er = 1'b0; sp = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (pr_v[i]) begin
                lat = k - 1; dl = ld_v[i]; er = er_v[i]; sp = sp_v[i];
                break;
            end
        end
        ler_v[i] = 1'b0; esc_v[i] = 1'b0;
        if (lat < 0) begin
            n_chk++; n_err++;
            $display("FAIL timeout[%0d]: no Pronto within 40 cycles", i);
        end
        @(negedge clk);
    endtask

    int         lat;
    logic [7:0] dl, sp;
    bit         er;

    initial begin
        for (int i = 0; i < 2; i++) begin end_v[i] = 8'h00; dw_v[i] = 8'h00; end
        repeat (3) @(negedge clk);
        chk("rst_pronto", 0, 32'(pr_v[0]), 32'd0);
        chk("rst_ocupado", 0, 32'(oc_v[0]), 32'd0);
        chk("rst_lido", 0, 32'(ld_v[0]), 32'h00);
        chk("rst_porta", 0, 32'(sp_v[0]), 32'h00);
        @(posedge clk); #2 rst_n = 1'b1;

        acesso(0, 1'b0, 1'b1, 8'h10, 8'hA5, lat, dl, er, sp);
        chk("wr_lat", 0, 32'(lat), 32'd3);
        chk("wr_erro", 0, 32'(er), 32'd0);
        acesso(0, 1'b1, 1'b0, 8'h10, 8'h00, lat, dl, er, sp);
        chk("rd_lat", 0, 32'(lat), 32'd3);
        chk("rd_dado", 0, 32'(dl), 32'hA5);
        chk("rd_erro", 0, 32'(er), 32'd0);

        acesso(0, 1'b0, 1'b1, 8'hFF, 8'h3C, lat, dl, er, sp);
        chk("porta_wr", 0, 32'(sp), 32'h3C);
        acesso(0, 1'b1, 1'b0, 8'hFF, 8'h00, lat, dl, er, sp);
        chk("porta_rd", 0, 32'(dl), 32'h3C);

        acesso(0, 1'b0, 1'b1, 8'h20, 8'h77, lat, dl, er, sp);
        acesso(0, 1'b1, 1'b1, 8'h20, 8'h99, lat, dl, er, sp);
        chk("ambos_erro", 0, 32'(er), 32'd1);
        chk("ambos_dado", 0, 32'(dl), 32'h3C);
        acesso(0, 1'b1, 1'b0, 8'h20, 8'h00, lat, dl, er, sp);
        chk("ambos_ram", 0, 32'(dl), 32'h77);

        acesso(1, 1'b0, 1'b1, 8'h00, 8'h5A, lat, dl, er, sp);
        chk("b_lat", 1, 32'(lat), 32'd1);
        acesso(1, 1'b1, 1'b0, 8'h40, 8'h00, lat, dl, er, sp);
        chk("fora_rd_dado", 1, 32'(dl), 32'h00);
        chk("fora_rd_erro", 1, 32'(er), 32'd1);
        acesso(1, 1'b0, 1'b1, 8'h40, 8'hEE, lat, dl, er, sp);
        chk("fora_wr_erro", 1, 32'(er), 32'd1);
        acesso(1, 1'b1, 1'b0, 8'h00, 8'h00, lat, dl, er, sp);
        chk("fora_wr_ram", 1, 32'(dl), 32'h5A);
        chk("fora_wr_erro0", 1, 32'(er), 32'd0);

        // Request held for 10 edges with no wait states: Pronto every third cycle.
        @(negedge clk);
        ler_v[1] = 1'b1; end_v[1] = 8'h00;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("retido_pronto", 1, 32'(pr_v[1]), (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k == 10) ler_v[1] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset during the wait phase of a write must abort it.
        acesso(0, 1'b0, 1'b1, 8'h05, 8'h11, lat, dl, er, sp);
        @(negedge clk);
        esc_v[0] = 1'b1; end_v[0] = 8'h05; dw_v[0] = 8'h22;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        esc_v[0] = 1'b0;
        chk("abort_pronto", 0, 32'(pr_v[0]), 32'd0);
        chk("abort_ocupado", 0, 32'(oc_v[0]), 32'd0);
        chk("abort_lido", 0, 32'(ld_v[0]), 32'h00);
        chk("abort_porta", 0, 32'(sp_v[0]), 32'h00);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        acesso(0, 1'b1, 1'b0, 8'h05, 8'h00, lat, dl, er, sp);
        chk("abort_ram", 0, 32'(dl), 32'h11);
        chk("abort_lat", 0, 32'(lat), 32'd3);

        for (int n = 0; n < 120; n++) begin
            int          i, op, sel;
            logic [7:0]  a;
            i   = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 9));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: a = 8'hFF;
                1: a = 8'($urandom_range(0, 15));
                2: a = 8'($urandom_range(16, 40));
                default: a = 8'($urandom_range(0, 255));
            endcase
            acesso(i, (op <= 4), (op == 0) || (op >= 5), a, 8'($urandom_range(0, 255)),
                   lat, dl, er, sp);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/memoria_dados_resp.md
Name: memoria_dados_resp

Overview:
Data-memory responder on the far end of the nRisc data interface. It answers the core's LerMem/EscMem requests on EndMemDados/DadoEscritoMem, and returns DadoLidoMem with a Pronto handshake after a programmable number of wait states. The block holds the data RAM and one memory-mapped output register (SaidaPorta). It sits beside the core in the top-level, between the core's data port and the board I/O.

Parameters:
PROFUNDIDADE, 256, number of 8-bit RAM words; legal range 2..256.
ESPERAS, 2, wait-state cycles inserted before Pronto; legal range 0..15.
END_PORTA, 8'hFF, address of the memory-mapped output register; never reaches RAM.

Ports:
Clock  input  1  system clock, rising edge.
ResetN  input  1  asynchronous active-low reset.
LerMem  input  1  read request, level, held by the core until Pronto.
EscMem  input  1  write request, level, held by the core until Pronto.
EndMemDados  input  8  access address.
DadoEscritoMem  input  8  write data.
DadoLidoMem  output  8  read data; valid in the Pronto cycle and held until the next read completes.
Pronto  output  1  one-cycle pulse marking access completion.
Ocupado  output  1  high from request capture until Pronto, inclusive.
Erro  output  1  one-cycle pulse, coincident with Pronto, for an illegal access.
SaidaPorta  output  8  memory-mapped output register.

Behaviour:
- Reset (ResetN low, asynchronous): state goes to OCIOSO. DadoLidoMem, SaidaPorta and the wait counter clear to 0. Pronto, Ocupado and Erro clear to 0. RAM contents are not reset.
- Reset mid-access: the access is aborted, with no RAM or SaidaPorta update and no Pronto.
- State machine:
  - OCIOSO: request sampled (LerMem or EscMem high) -> latch address, data and operation into internal registers, load the counter with ESPERAS, go to ESPERA. If ESPERAS=0, go straight to RESPONDE.
  - ESPERA: decrement the counter each cycle; when it reaches 0, go to RESPONDE.
  - RESPONDE: perform the access, pulse Pronto for one cycle, then go to RETORNO.
  - RETORNO: one dead cycle; requests are ignored here. Go to OCIOSO.
- Timing:
  - Latency from the sampling edge to Pronto is ESPERAS+1 cycles.
  - Minimum spacing between accesses is ESPERAS+3 cycles.
  - RETORNO guarantees a request still held after Pronto is not re-executed unless it is still high back in OCIOSO. The core must drop its request in the cycle after Pronto.
- Inputs are ignored outside OCIOSO; only the latched values are used.
- Write, legal address: RAM[addr] <= data in the RESPONDE cycle.
- Write to END_PORTA: SaidaPorta <= data; RAM is not written.
- Read, legal address: DadoLidoMem <= RAM[addr], registered and visible in the Pronto cycle.
- Read from END_PORTA: returns SaidaPorta.
- Illegal cases (each pulses Erro together with Pronto):
  - LerMem and EscMem both high at capture: no RAM or port change, DadoLidoMem unchanged.
  - Address not equal to END_PORTA and address >= PROFUNDIDADE: reads return 8'h00, writes are discarded.
- Address width is 8 bits; there is no wrap-around. Out-of-range addresses use the error path above.

Decomposition:
- Shared package memoria_pkg:
  - state encoding (OCIOSO=2'd0, ESPERA=2'd1, RESPONDE=2'd2, RETORNO=2'd3);
  - default END_PORTA;
  - wait-counter width (4).
- One sub-module, ram_dados_sinc: a synchronous-write, registered-read PROFUNDIDADE x 8 array with enable, write-enable, address, data-in and data-out ports. It has no reset.
- The FSM, port register and error logic stay in memoria_dados_resp.

Test Plan:
- Write then read, ESPERAS=2: EscMem, addr 8'h10, data 8'hA5 -> Pronto exactly 3 cycles after the capture edge. Then LerMem at 8'h10 -> DadoLidoMem=8'hA5 in the Pronto cycle, Erro=0.
- Port write/read: EscMem at 8'hFF, data 8'h3C -> SaidaPorta=8'h3C and RAM[8'hFF] unchanged. LerMem at 8'hFF -> 8'h3C.
- Both requests high at 8'h20 -> Pronto and Erro pulse together; RAM[8'h20] and DadoLidoMem unchanged.
- PROFUNDIDADE=16: LerMem at 8'h40 -> DadoLidoMem=8'h00 with Erro. EscMem at 8'h40 -> no RAM change, Erro.
- Request held continuously for 10 cycles, ESPERAS=0 -> Pronto in cycle 1, then again in cycle 4, i.e. a spacing of 3. Confirms the RETORNO dead cycle.
- ResetN pulsed low during ESPERA of a write to 8'h05 (previously 8'h11) -> no Pronto, RAM[8'h05] still 8'h11, all outputs 0, state OCIOSO.
